// File: rtl/pwl_activation_unit.sv
// pwl_activation_unit: piecewise-linear activation with two runtime-writable
// lookup tables (bank 0 = tanh, bank 1 = sigmoid) and a 3-stage pipeline.
// Build option: define PWL_INTERP_EN to interpolate linearly between adjacent
// table entries; leave it undefined for a step function (out_data = base).
// Latency and handshake behaviour are the same in both builds.
module pwl_activation_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FRAC_W = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [ADDR_W+FRAC_W-1:0]   in_data,
  input  logic                              in_bank,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [DATA_W-1:0]          out_data,
  input  logic                              lut_we,
  input  logic                              lut_bank,
  input  logic        [ADDR_W-1:0]          lut_waddr,
  input  logic signed [DATA_W-1:0]          lut_wdata
);

  localparam int IN_W  = ADDR_W + FRAC_W;
  localparam int DEPTH = 1 << ADDR_W;

`ifdef PWL_INTERP_EN
  localparam int SUM_W  = DATA_W + 2;
  localparam int PROD_W = DATA_W + FRAC_W + 2;
  localparam logic [ADDR_W-1:0] IDX_MAX  = {1'b0, {(ADDR_W-1){1'b1}}};
  localparam logic [ADDR_W-1:0] IDX_ONES = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DATA_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp a widened sum into the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction
`endif

  // Table storage and pipeline state.
  logic signed [DATA_W-1:0] lut_q [2][DEPTH];
  logic signed [DATA_W-1:0] lut_d [2][DEPTH];

  logic                     vld_p1_q, vld_p1_d;
  logic [ADDR_W-1:0]        idx_p1_q, idx_p1_d;
  logic                     bank_p1_q, bank_p1_d;
  logic signed [DATA_W-1:0] base_p1;

  logic                     vld_p2_q, vld_p2_d;
  logic signed [DATA_W-1:0] base_p2_q, base_p2_d;

  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic signed [DATA_W-1:0] result_p2;

`ifdef PWL_INTERP_EN
  logic [FRAC_W-1:0]        frac_p1_q, frac_p1_d;
  logic [ADDR_W-1:0]        idx_inc_p1;
  logic signed [DATA_W-1:0] next_p1;
  logic signed [DATA_W:0]   diff_p1;
  logic signed [PROD_W-1:0] diff_x_p1, frac_x_p1;
  logic signed [PROD_W-1:0] prod_p2_q, prod_p2_d;
  logic signed [SUM_W-1:0]  shift_p2, sum_p2;
`else
  logic unused_frac;
  assign unused_frac = ^in_data[FRAC_W-1:0];
`endif

  // A stalled output freezes every stage at once.
  logic stall, adv;
  assign stall     = out_valid_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Table write port; never gated by a stall.
  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d[lut_bank][lut_waddr] = lut_wdata;
  end

  // S1: capture segment index, fraction and bank of the accepted operand.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    idx_p1_d  = idx_p1_q;
    bank_p1_d = bank_p1_q;
`ifdef PWL_INTERP_EN
    frac_p1_d = frac_p1_q;
`endif
    if (adv) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        idx_p1_d  = in_data[IN_W-1:FRAC_W];
        bank_p1_d = in_bank;
`ifdef PWL_INTERP_EN
        frac_p1_d = in_data[FRAC_W-1:0];
`endif
      end
    end
  end

  // S1 fetch: read base and neighbour from the current table contents.
  always_comb begin
    base_p1 = lut_q[bank_p1_q][idx_p1_q];
`ifdef PWL_INTERP_EN
    idx_inc_p1 = idx_p1_q + IDX_ONE;
    next_p1    = lut_q[bank_p1_q][idx_inc_p1];
    if (idx_p1_q == IDX_MAX)       next_p1 = base_p1;
    else if (idx_p1_q == IDX_ONES) next_p1 = lut_q[bank_p1_q][{ADDR_W{1'b0}}];
`endif
  end

`ifdef PWL_INTERP_EN
  assign diff_p1   = (DATA_W+1)'(next_p1) - (DATA_W+1)'(base_p1);
  assign diff_x_p1 = PROD_W'(diff_p1);
  assign frac_x_p1 = PROD_W'({1'b0, frac_p1_q});
`endif

  // S2: form the slope product (or just carry base in the step build).
  always_comb begin
    vld_p2_d  = vld_p2_q;
    base_p2_d = base_p2_q;
`ifdef PWL_INTERP_EN
    prod_p2_d = prod_p2_q;
`endif
    if (adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        base_p2_d = base_p1;
`ifdef PWL_INTERP_EN
        prod_p2_d = diff_x_p1 * frac_x_p1;
`endif
      end
    end
  end

`ifdef PWL_INTERP_EN
  assign shift_p2  = SUM_W'(prod_p2_q >>> FRAC_W);
  assign sum_p2    = SUM_W'(base_p2_q) + shift_p2;
  assign result_p2 = sat(sum_p2);
`else
  assign result_p2 = base_p2_q;
`endif

  // S3: output register; data only changes when a valid result lands.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      out_valid_d = vld_p2_q;
      if (vld_p2_q) out_data_d = result_p2;
    end
  end

  // Control, output and table state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < DEPTH; i++)
          lut_q[b][i] <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      lut_q       <= lut_d;
    end
  end

  // Datapath registers; qualified by the valids, so no reset needed.
  always_ff @(posedge clk) begin
    idx_p1_q  <= idx_p1_d;
    bank_p1_q <= bank_p1_d;
    base_p2_q <= base_p2_d;
`ifdef PWL_INTERP_EN
    frac_p1_q <= frac_p1_d;
    prod_p2_q <= prod_p2_d;
`endif
  end

endmodule

// File: doc/pwl_activation_unit.md
PWL_ACTIVATION_UNIT -- requirements
Module: pwl_activation_unit

Interface
REQ-001 Parameter DATA_W, 8: signed width of LUT entries and out_data.
REQ-002 Parameter ADDR_W, 4: LUT index bits; each bank holds 2**ADDR_W entries.
REQ-003 Parameter FRAC_W, 4: interpolation fraction bits; input width IN_W = ADDR_W+FRAC_W.
REQ-004 Ports: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous and active-low.
REQ-005 in_valid in 1, in_ready out 1, in_data in IN_W (signed), in_bank in 1: input handshake, operand and bank select (0 = tanh, 1 = sigmoid).
REQ-006 out_valid out 1, out_ready in 1, out_data out DATA_W (signed): output handshake and result.
REQ-007 lut_we in 1, lut_bank in 1, lut_waddr in ADDR_W, lut_wdata in DATA_W: runtime table write port.

Function
REQ-008 Index idx = in_data[IN_W-1:FRAC_W], read as a two's-complement segment number; frac = in_data[FRAC_W-1:0], read as unsigned.
REQ-009 base = lut[bank][idx].
REQ-010 next:
- idx = 2**(ADDR_W-1)-1 (most positive index): next = base (clamp).
- idx = all ones: next = lut[bank][0] (wrap from -1 to 0).
- Otherwise: next = lut[bank][idx+1].
REQ-011 Result = base + ((next-base)*frac >>> FRAC_W).
- Difference is DATA_W+1 bits signed; frac is zero-extended.
- The shift is arithmetic (floor).
- The sum saturates to the signed DATA_W range.
REQ-012 Pipeline has 3 registered stages:
- S1: register idx/frac/bank, fetch base/next.
- S2: form the product.
- S3: add, saturate, drive out_data.
- Latency from in_valid&&in_ready to out_valid is 3 cycles.
REQ-013 Transfer occurs only when valid and ready are both high in the same cycle; throughput is one operand per cycle with no bubbles while out_ready is held high.
REQ-014 Stall: when out_valid=1 and out_ready=0, every stage holds.
- in_ready = !(out_valid && !out_ready).
- No operand is dropped, duplicated or reordered.
REQ-015 out_data and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-016 lut_we writes lut[lut_bank][lut_waddr] at the clock edge.
- An S1 read in the same cycle returns the old value.
- Operands accepted on later cycles see the new value.
- Writes are never blocked by a stall.
REQ-017 Bubbles (in_valid=0) propagate as out_valid=0 slots; out_data holds its previous value when out_valid=0.

Reset
REQ-018 rst_n low asynchronously clears all stage valids, out_valid, out_data and every entry of both LUT banks to 0; in_ready reads 1 during and after reset.
REQ-019 Reset asserted mid-operation discards all in-flight operands; the first output after release belongs to an operand accepted after release.

Configuration
REQ-020 Macro PWL_INTERP_EN.
- Defined: interpolation per REQ-011.
- Undefined: out_data = base (step function), the product stage is removed, and latency and handshake stay identical (3 cycles).

Verification (DATA_W=8, ADDR_W=4, FRAC_W=4, PWL_INTERP_EN defined)
Preload for every scenario: bank 0 written with idx0..15 = 0,12,15,15,15,15,15,15,-15,-15,-15,-15,-15,-15,-15,-12 through the write port.
REQ-021 Segment interior and exact point:
- in_data=0x08 -> 6, three cycles later.
- in_data=0x10 -> 12.
REQ-022 Clamp and wrap:
- in_data=0x78 -> 15 (next clamped).
- in_data=0xF8 -> -6 (next wraps to entry 0).
REQ-023 Backpressure:
- Stimulus: 6 back-to-back operands with out_ready low for cycles 4-8.
- Required: in_ready falls on the same cycle out_valid=1&&out_ready=0; all 6 results appear in order with no loss.
REQ-024 Write/read collision:
- Stimulus: lut_we writes idx1=20 in the same cycle operand 0x10 is in S1; operand 0x10 issued again one cycle later.
- Required: first result is 12, second is 20.
REQ-025 Reset mid-stream:
- Stimulus: rst_n pulsed low with 2 operands in flight.
- Required: out_valid is 0 immediately; the LUT reads 0 (0x08 -> 0 after reset).
REQ-026 Macro undefined: in_data=0x08 -> 0, 0x18 -> 12, latency still 3.
